// File: rtl/ram_dump_pkg.sv
// Shared widths and the FSM state type for the RAM dump reader.
// Optional feature macro: RAM_DUMP_CHECKSUM_EN adds a checksum word (CSUM state).
package ram_dump_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  // Last word address of a dump; the pointer stops here and never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
`ifdef RAM_DUMP_CHECKSUM_EN
    ,
    ST_CSUM    = 3'd5
`endif
  } state_t;

endpackage : ram_dump_pkg

// File: rtl/ram_dump_reader.sv
// Dumps all 16 words of a synchronous-read RAM onto a valid/ready stream.
// Per word: READ issues rd_en, WAIT captures rd_data, PRESENT offers the word.
// Optional feature macro: RAM_DUMP_CHECKSUM_EN appends a modulo-256 sum of the
// 16 dumped words as a 17th word (dump_addr = 0) before DONE.
//
// Handshake: a word moves on a rising clk edge where dump_valid and dump_ready
// are both 1. dump_valid, once raised, stays high with dump_addr/dump_data
// unchanged until that edge; dump_ready is ignored while dump_valid is low.
module ram_dump_reader
  import ram_dump_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              xfer;
  logic              last_word;

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign xfer      = dump_valid & dump_ready;
  assign last_word = (ptr == LAST_ADDR);

  // State register; reset parks the FSM in IDLE from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start only matters in IDLE, dump_ready only while presenting.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_READ;
      ST_READ:    state_nxt = ST_WAIT;
      ST_WAIT:    state_nxt = ST_PRESENT;
      ST_PRESENT: begin
        if (dump_ready) begin
          if (!last_word) begin
            state_nxt = ST_READ;
          end else begin
`ifdef RAM_DUMP_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef RAM_DUMP_CHECKSUM_EN
      ST_CSUM:    if (dump_ready) state_nxt = ST_DONE;
`endif
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    rd_en      = (state == ST_READ);
    rd_addr    = ptr;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
`ifdef RAM_DUMP_CHECKSUM_EN
    dump_valid = (state == ST_PRESENT) || (state == ST_CSUM);
`else
    dump_valid = (state == ST_PRESENT);
`endif
  end

  // Pointer, output word register and (optionally) the running checksum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      dump_addr <= '0;
      dump_data <= '0;
`ifdef RAM_DUMP_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr <= '0;
`ifdef RAM_DUMP_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // RAM data is valid the cycle after rd_en, i.e. now.
          dump_data <= rd_data;
          dump_addr <= ptr;
        end
        ST_PRESENT: begin
          if (xfer) begin
            if (!last_word) ptr <= ptr + 1'b1;
`ifdef RAM_DUMP_CHECKSUM_EN
            csum <= csum + dump_data;
            // The final sum includes the word leaving on this edge.
            if (last_word) begin
              dump_data <= csum + dump_data;
              dump_addr <= '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule : ram_dump_reader
